// File: rtl/xrbus_integrity_pkg.sv
// Shared types and constants for the XR-BUS integrity scheduler.
package xrbus_integrity_pkg;

  localparam int XRBUS_FRAME_W = 4096;
  localparam int XRBUS_VER_W   = 8;

  // Scheduler sequence: accept -> issue to checker -> wait latency -> respond.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/xrbus_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr and wraps.
// gnt is one-hot (all zero when nothing is requested); idx is its encoding.
module xrbus_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W-1:0] pos;

  // Walk the requesters from ptr+1 around to ptr; the first active one wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 1; k <= N; k++) begin
      pos = IDX_W'((int'(ptr) + k) % N);
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/xrbus_integrity_sched.sv
// Shares one XR-BUS integrity checker among N_REQ frame sources. One frame is
// in flight at a time; the verdict goes back tagged with the requester index
// and saturating pass/fail statistics are kept.
module xrbus_integrity_sched
  import xrbus_integrity_pkg::*;
#(
  parameter int  N_REQ   = 4,
  parameter int  FRAME_W = XRBUS_FRAME_W,
  parameter int  CHK_LAT = 1,
  parameter int  CNT_W   = 16,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*FRAME_W-1:0] req_frame,
  output logic [N_REQ-1:0]         req_ready,
  output logic [FRAME_W-1:0]       chk_frame,
  output logic                     chk_frame_valid,
  input  logic                     chk_out_valid,
  input  logic                     chk_version_compatible,
  input  logic [XRBUS_VER_W-1:0]   chk_frame_version,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic                     resp_pass,
  output logic [XRBUS_VER_W-1:0]   resp_version,
  input  logic                     clear_stats,
  output logic [CNT_W-1:0]         pass_cnt,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic                     busy
);

  localparam int LAT_W = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;

  sched_state_e           state_q, state_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]        win_q, win_d;
  logic [FRAME_W-1:0]     frame_q, frame_d;
  logic [LAT_W-1:0]       lat_q, lat_d;
  logic                   pass_q, pass_d;
  logic [XRBUS_VER_W-1:0] ver_q, ver_d;
  logic [CNT_W-1:0]       pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]       fail_cnt_q, fail_cnt_d;
  logic                   resp_hs;

  logic [N_REQ-1:0]       arb_gnt;
  logic [ID_W-1:0]        arb_idx;

  xrbus_rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the frame/verdict datapath that follows the sequence.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    frame_d  = frame_q;
    lat_d    = lat_q;
    pass_d   = pass_q;
    ver_d    = ver_q;
    resp_hs  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          win_d   = arb_idx;
          frame_d = req_frame[arb_idx*FRAME_W +: FRAME_W];
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        lat_d   = LAT_W'(CHK_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          // A missing result valid counts as a failed frame.
          pass_d  = chk_out_valid & chk_version_compatible;
          ver_d   = chk_frame_version;
          state_d = S_RESP;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_hs  = 1'b1;
          rr_ptr_d = win_q;
          state_d  = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Saturating statistics; a clear in the same cycle as an increment wins.
  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (clear_stats) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
    end else if (resp_hs && pass_q) begin
      if (pass_cnt_q != '1) begin
        pass_cnt_d = pass_cnt_q + CNT_W'(1);
      end else begin
        pass_cnt_d = pass_cnt_q;
      end
    end else if (resp_hs) begin
      if (fail_cnt_q != '1) begin
        fail_cnt_d = fail_cnt_q + CNT_W'(1);
      end else begin
        fail_cnt_d = fail_cnt_q;
      end
    end else begin
      pass_cnt_d = pass_cnt_q;
    end
  end

  // Datapath and statistics registers; reset points arbitration at requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= ID_W'(N_REQ - 1);
      win_q      <= '0;
      frame_q    <= '0;
      lat_q      <= '0;
      pass_q     <= 1'b0;
      ver_q      <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      win_q      <= win_d;
      frame_q    <= frame_d;
      lat_q      <= lat_d;
      pass_q     <= pass_d;
      ver_q      <= ver_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  // Grant is only offered in IDLE, and is forced low while reset is held.
  assign req_ready       = (state_q == S_IDLE && !rst) ? arb_gnt : '0;
  assign chk_frame       = frame_q;
  assign chk_frame_valid = (state_q == S_ISSUE);
  assign resp_valid      = (state_q == S_RESP);
  assign resp_id         = win_q;
  assign resp_pass       = pass_q;
  assign resp_version    = ver_q;
  assign pass_cnt        = pass_cnt_q;
  assign fail_cnt        = fail_cnt_q;
  assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_xrbus_integrity_sched.sv
// Scoreboard bench for xrbus_integrity_sched with a behavioural checker stand-in
// (latency CHK_LAT, compatible when version >= 0x03).
module tb_xrbus_integrity_sched;

  localparam int N   = 4;
  localparam int FW  = 64;
  localparam int LAT = 1;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  typedef struct packed {
    logic [1:0] id;
    logic       pass;
    logic [7:0] ver;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*FW-1:0] req_frame;
  logic [N-1:0]    req_ready;
  logic [FW-1:0]   chk_frame;
  logic            chk_frame_valid;
  logic            chk_out_valid;
  logic            chk_version_compatible;
  logic [7:0]      chk_frame_version;
  logic            resp_valid;
  logic            resp_ready;
  logic [1:0]      resp_id;
  logic            resp_pass;
  logic [7:0]      resp_version;
  logic            clear_stats;
  logic [CW-1:0]   pass_cnt;
  logic [CW-1:0]   fail_cnt;
  logic            busy;

  xrbus_integrity_sched #(
    .N_REQ   (N),
    .FRAME_W (FW),
    .CHK_LAT (LAT),
    .CNT_W   (CW)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .req_valid              (req_valid),
    .req_frame              (req_frame),
    .req_ready              (req_ready),
    .chk_frame              (chk_frame),
    .chk_frame_valid        (chk_frame_valid),
    .chk_out_valid          (chk_out_valid),
    .chk_version_compatible (chk_version_compatible),
    .chk_frame_version      (chk_frame_version),
    .resp_valid             (resp_valid),
    .resp_ready             (resp_ready),
    .resp_id                (resp_id),
    .resp_pass              (resp_pass),
    .resp_version           (resp_version),
    .clear_stats            (clear_stats),
    .pass_cnt               (pass_cnt),
    .fail_cnt               (fail_cnt),
    .busy                   (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model state
  exp_t       exp_q[$];
  bit         m_idle  = 1'b1;
  int         m_ptr   = N - 1;
  int         m_acc   = 0;
  int         m_win   = 0;
  bit         m_wpass = 1'b0;
  logic [FW-1:0] m_frame = '0;
  int         m_pass  = 0;
  int         m_fail  = 0;

  // driver state
  int remaining[N];
  int ver_sel[N];
  int rr_mode   = 0;
  bit clr_on_hs = 1'b0;
  bit rand_clear = 1'b0;
  int stall     = 0;
  bit last_cv   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // first active requester after ptr, wrapping; -1 if none
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (ptr + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // Timeline reference model: arbitration, latency, RESP window and counters.
  always @(negedge clk) begin : ref_model
    logic [N-1:0] exp_ready;
    int   w;
    bit   exp_cv, exp_rv, hs;
    exp_t e;
    logic [7:0] v;
    if (rst) begin
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_chk_frame", chk_frame, 64'd0);
      check("rst_chk_frame_valid", 64'(chk_frame_valid), 64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_resp_fields", {53'd0, resp_id, resp_pass, resp_version}, 64'd0);
      check("rst_counters", {56'd0, pass_cnt, fail_cnt}, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      m_idle = 1'b1;
      m_ptr  = N - 1;
      m_pass = 0;
      m_fail = 0;
      exp_q.delete();
    end else begin
      check("pass_cnt", 64'(pass_cnt), 64'(m_pass));
      check("fail_cnt", 64'(fail_cnt), 64'(m_fail));
      w = m_idle ? pick(req_valid, m_ptr) : -1;
      exp_ready = (w >= 0) ? (N'(1) << w) : '0;
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("busy", 64'(busy), 64'(!m_idle));
      exp_cv = !m_idle && (cyc == m_acc + 1);
      check("chk_frame_valid", 64'(chk_frame_valid), 64'(exp_cv));
      if (exp_cv) check("chk_frame", chk_frame, m_frame);
      exp_rv = !m_idle && (cyc >= m_acc + 2 + LAT);
      check("resp_valid", 64'(resp_valid), 64'(exp_rv));
      hs = exp_rv && resp_ready;
      if (hs) begin
        m_idle = 1'b1;
        m_ptr  = m_win;
      end else if (w >= 0) begin
        m_idle  = 1'b0;
        m_acc   = cyc;
        m_win   = w;
        m_frame = req_frame[w*FW +: FW];
        v       = m_frame[7:0];
        e.id    = 2'(w);
        e.pass  = (v >= 8'h03);
        e.ver   = v;
        m_wpass = e.pass;
        exp_q.push_back(e);
      end
      if (clear_stats) begin
        m_pass = 0;
        m_fail = 0;
      end else if (hs && m_wpass) begin
        m_pass = (m_pass < SAT) ? m_pass + 1 : SAT;
      end else if (hs) begin
        m_fail = (m_fail < SAT) ? m_fail + 1 : SAT;
      end
    end
  end

  // Monitor: whenever a verdict is presented, compare it with the queue head.
  always @(negedge clk) begin : resp_monitor
    exp_t e;
    if (!rst && resp_valid) begin
      check("resp_has_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check("resp_id", 64'(resp_id), 64'(e.id));
        check("resp_pass", 64'(resp_pass), 64'(e.pass));
        check("resp_version", 64'(resp_version), 64'(e.ver));
        if (resp_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Checker stand-in: result valid CHK_LAT cycles after the issue strobe.
  initial begin : checker_model
    int pend;
    logic [7:0] pv;
    pend = 0;
    pv   = 8'h00;
    chk_out_valid = 1'b0;
    chk_version_compatible = 1'b0;
    chk_frame_version = 8'h00;
    forever begin
      @(negedge clk);
      chk_out_valid = 1'b0;
      chk_version_compatible = 1'b0;
      chk_frame_version = 8'h00;
      if (rst) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            chk_out_valid = 1'b1;
            chk_frame_version = pv;
            chk_version_compatible = (pv >= 8'h03);
          end
        end
        if (chk_frame_valid) begin
          pend = LAT;
          pv   = chk_frame[7:0];
        end
      end
    end
  end

  task automatic load_frame(input int i);
    logic [FW-1:0] f;
    f = {$urandom, $urandom};
    f[7:0] = (ver_sel[i] >= 0) ? 8'(ver_sel[i]) : 8'($urandom_range(0, 7));
    req_frame[i*FW +: FW] = f;
  endtask

  // One clock: sample at negedge, then update requesters and resp_ready after posedge.
  task automatic step();
    logic [N-1:0] acc;
    bit rv, hs;
    @(negedge clk);
    acc = req_ready;
    rv  = resp_valid;
    hs  = resp_valid & resp_ready;
    last_cv = chk_frame_valid;
    @(posedge clk);
    #1;
    clear_stats = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        remaining[i]--;
        req_valid[i] = 1'b0;
      end
      if (remaining[i] > 0 && !req_valid[i]) begin
        req_valid[i] = 1'b1;
        load_frame(i);
      end
    end
    case (rr_mode)
      0: resp_ready = 1'b1;
      1: resp_ready = 1'($urandom_range(0, 1));
      default: begin
        if (hs) stall = 0;
        else if (rv) stall++;
        resp_ready = (stall >= 5);
        if (resp_ready && clr_on_hs) clear_stats = 1'b1;
      end
    endcase
    if (rand_clear && $urandom_range(0, 15) == 0) clear_stats = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      step();
      n++;
      done = (req_valid == '0) && m_idle && (exp_q.size() == 0);
      for (int i = 0; i < N; i++) if (remaining[i] != 0) done = 1'b0;
    end
    check("drain_within_budget", 64'(done), 64'd1);
  endtask

  initial begin : stimulus
    rst = 1'b1;
    req_valid = '0;
    req_frame = '0;
    resp_ready = 1'b0;
    clear_stats = 1'b0;
    for (int i = 0; i < N; i++) begin
      remaining[i] = 0;
      ver_sel[i] = -1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // single passing frame, then a failing one, then requester 3 to park the pointer
    ver_sel[0] = 5;  remaining[0] = 1;  wait_done(50);
    ver_sel[2] = 1;  remaining[2] = 1;  wait_done(50);
    ver_sel[3] = 4;  remaining[3] = 1;  wait_done(50);

    // all four requesting: order 0,1,2,3,0 at the minimum period
    for (int i = 0; i < N; i++) begin
      ver_sel[i] = 6;
      remaining[i] = 1;
    end
    remaining[0] = 2;
    wait_done(100);

    // consumer stalls five cycles in RESP
    rr_mode = 2;  stall = 0;  resp_ready = 1'b0;
    remaining[1] = 1;
    wait_done(100);

    // saturation of a 4-bit counter, then clear colliding with an increment
    rr_mode = 1;
    clear_stats = 1'b1;
    step();
    ver_sel[1] = 7;  remaining[1] = 17;  wait_done(400);
    rr_mode = 2;  stall = 0;  clr_on_hs = 1'b1;
    remaining[1] = 1;  wait_done(100);
    clr_on_hs = 1'b0;

    // reset in WAIT drops the frame; arbitration restarts at requester 0
    rr_mode = 0;
    ver_sel[3] = 5;  remaining[3] = 1;
    last_cv = 1'b0;
    for (int k = 0; k < 20 && !last_cv; k++) step();
    check("issue_seen_before_reset", 64'(last_cv), 64'd1);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    ver_sel[0] = 5;
    remaining[0] = 1;
    remaining[3] = 1;
    req_valid[0] = 1'b1;  load_frame(0);
    req_valid[3] = 1'b1;  load_frame(3);
    wait_done(100);

    // randomized traffic with random backpressure and occasional clears
    rr_mode = 1;
    rand_clear = 1'b1;
    for (int i = 0; i < N; i++) begin
      ver_sel[i] = -1;
      remaining[i] = $urandom_range(5, 15);
    end
    wait_done(3000);
    rand_clear = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xrbus_integrity_sched.md
# xrbus_integrity_sched

Round-robin scheduler that shares one XR-BUS integrity/version checker among `N_REQ` frame sources. It accepts one frame at a time over a valid/ready handshake, issues it to the checker, and waits a fixed checker latency. It then returns a pass/fail verdict with the frame version to the originating requester and keeps saturating pass/fail statistics. It sits between the XR-BUS ingress ports and the single `xrbus_integrity` instance.

## Interface
- `N_REQ`, 4: number of requesters, ≥ 2.
- `FRAME_W`, 4096: frame width in bits.
- `CHK_LAT`, 1: checker latency in cycles, from `chk_frame_valid` to result valid; ≥ 1.
- `CNT_W`, 16: width of the statistics counters.

Clock and reset (already decided): one clock, `clk`; reset `rst`, asynchronous, active-high.

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous reset, active-high.
- `req_valid`, in, `N_REQ`: per-requester frame valid.
- `req_frame`, in, `N_REQ*FRAME_W`: requester i occupies bits `[i*FRAME_W +: FRAME_W]`.
- `req_ready`, out, `N_REQ`: one-hot accept strobe.
- `chk_frame`, out, `FRAME_W`: frame driven to the checker.
- `chk_frame_valid`, out, 1: single-cycle issue strobe to the checker.
- `chk_out_valid`, in, 1: checker result valid.
- `chk_version_compatible`, in, 1: checker compatibility flag.
- `chk_frame_version`, in, 8: version reported by the checker.
- `resp_valid`, out, 1: verdict available.
- `resp_ready`, in, 1: consumer accepts the verdict.
- `resp_id`, out, `$clog2(N_REQ)`: index of the originating requester.
- `resp_pass`, out, 1: 1 = compatible and forwarded.
- `resp_version`, out, 8: sampled frame version.
- `clear_stats`, in, 1: synchronous clear of both counters.
- `pass_cnt`, out, `CNT_W`: saturating pass count.
- `fail_cnt`, out, `CNT_W`: saturating fail count.
- `busy`, out, 1: high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - Round-robin search starts at `rr_ptr+1` and wraps at `N_REQ-1`.
  - The first asserted `req_valid` wins. Only the winner sees `req_ready`=1, combinationally in the same cycle.
  - On the accept cycle: latch the frame and the winner index; go to ISSUE.
  - If no `req_valid` is asserted, remain in IDLE and leave `rr_ptr` unchanged.
- ISSUE:
  - `chk_frame_valid`=1 for exactly one cycle. `chk_frame` holds the latched frame from here until the next accept.
  - Load `lat_cnt` = `CHK_LAT-1`; go to WAIT.
- WAIT:
  - Decrement `lat_cnt` each cycle.
  - When `lat_cnt`==0: sample `pass` = `chk_out_valid & chk_version_compatible` and sample `chk_frame_version`; go to RESP.
- RESP:
  - `resp_valid`=1. `resp_id`, `resp_pass` and `resp_version` stay stable until `resp_valid & resp_ready`.
  - On that handshake: set `rr_ptr` to the winner index, update the statistics, return to IDLE.
- Statistics:
  - Increment `pass_cnt` or `fail_cnt` on the RESP handshake.
  - Both counters saturate at `2^CNT_W-1`.
  - If `clear_stats` coincides with an increment, the clear wins and the result is 0.
- No new `req_ready` is issued while `busy`. Requesters hold `req_valid` and their frame until accepted.

## Timing
- Reset values:
  - All outputs are 0: `req_ready`, `chk_frame`, `chk_frame_valid`, `resp_*`, counters, `busy`.
  - State = IDLE; `rr_ptr` = `N_REQ-1`, so requester 0 has first priority.
- Latency, with accept at cycle T:
  - `chk_frame_valid` at T+1.
  - Result sampled at T+1+`CHK_LAT`.
  - `resp_valid` at T+2+`CHK_LAT`.
- Minimum frame period: 3+`CHK_LAT` cycles, achieved with `resp_ready` tied high.
- Reset asserted mid-operation:
  - Outputs clear immediately; the in-flight frame is dropped with no response and no counter change.
  - After release, arbitration restarts from requester 0.
- A `req_valid` deasserting during the accept cycle is a protocol violation; the behaviour is undefined and is not checked.

## Structure
- Package `xrbus_integrity_pkg` holds:
  - the `sched_state_e` enum;
  - `XRBUS_FRAME_W` = 4096;
  - `XRBUS_VER_W` = 8.
- One sub-module, `xrbus_rr_arbiter`: parameterised on N; inputs `req` and `ptr`; outputs one-hot `gnt` and the encoded index; purely combinational.
- The FSM, latency counter and statistics live in the top module.

## Test plan
The bench pairs this block with `xrbus_integrity` (`CHK_LAT`=1, `min_compatible`=0x03).
- Requester 0, frame version field 0x05, accepted at T → `chk_frame_valid` at T+1, `resp_valid` at T+3, `resp_id`=0, `resp_pass`=1, `resp_version`=0x05, `pass_cnt`=1.
- Requester 2, version 0x01 → `resp_pass`=0, `resp_version`=0x01, `fail_cnt`=1, `pass_cnt` unchanged.
- All four `req_valid` held high, `resp_ready`=1 → accepts in order 0,1,2,3,0, spaced 4 cycles apart.
- `resp_ready` held low 5 cycles in RESP → `resp_*` stable, `req_ready` all 0, `busy`=1 throughout; handshake on cycle 6 → IDLE the next cycle.
- `CNT_W`=4, 17 passing frames → `pass_cnt`=15. `clear_stats` on the same cycle as an increment → `pass_cnt`=0.
- `rst` pulsed during WAIT for requester 3 → outputs 0 immediately and no response for the dropped frame; requesters 0 and 3 valid after release → requester 0 is granted first.
